pipe_stage_skid: RTL

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It is the next generation of the fixed IF/DE register and can be placed between any two loopyV stages, such as IF/DE or DE/EX. Back-pressure propagates through a registered `in_ready` instead of a global stall line. A `flush` input squashes in-flight beats and presents a configurable bubble payload.

---
 rtl/loopyV_data_types.sv | 27 ++
 rtl/pipe_stage_skid.sv | 99 +++++++++
 2 files changed

// File: rtl/loopyV_data_types.sv
// Shared loopyV types and constants used by the pipeline stage registers.
package loopyV_data_types;

  // Canonical RISC-V NOP: addi x0, x0, 0.
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Occupancy state of a skid-buffered pipeline stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  // Number of beats held in a given stage state.
  function automatic logic [1:0] pipe_level(input pipe_state_t state);
    logic [1:0] lvl;
    lvl = 2'd0;
    case (state)
      EMPTY:   lvl = 2'd0;
      FULL:    lvl = 2'd1;
      SKID:    lvl = 2'd2;
      default: lvl = 2'd0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// The main register always drives out_data; the skid register absorbs the one beat that
// can arrive while downstream stalls, so in_ready is a pure function of registered state.
module pipe_stage_skid
  import loopyV_data_types::*;
#(
  parameter int unsigned       DATA_W      = 64,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'({32'h0000_0000, RV_NOP})
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;

  // Outputs come straight from registered state, so no ready path crosses the stage.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != SKID);
  assign level     = pipe_level(state_q);
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and payload movement for the three-state occupancy FSM.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Squash everything, including any beat offered this cycle.
      state_d = EMPTY;
      main_d  = BUBBLE_DATA;
      skid_d  = BUBBLE_DATA;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = FULL;
            main_d  = in_data;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            // Downstream stalled: park the new beat, keep the head stable.
            state_d = SKID;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = BUBBLE_DATA;
          end
        end
        SKID: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            state_d = FULL;
            main_d  = skid_q;
            skid_d  = BUBBLE_DATA;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty stage.
          state_d = EMPTY;
          main_d  = BUBBLE_DATA;
          skid_d  = BUBBLE_DATA;
        end
      endcase
    end
  end

  // State, main and skid registers; reset drops held beats immediately.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_DATA;
      skid_q  <= BUBBLE_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
